// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: fixed-latency busy/ready handshake, byte-lane stores,
// sign/zero-extended loads. Define DMEM_MISALIGN_TRAP_EN to trap misaligned word/half accesses.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  memwrite,
  input  logic [1:0]  ldsize,
  input  logic        ldunsigned,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [31:0]     readdata_q, readdata_d;

  // Operands captured at acceptance; inputs are ignored while an access is in flight.
  logic [1:0]      memwrite_q;
  logic [1:0]      ldsize_q;
  logic            ldunsigned_q;
  logic [31:0]     adr_q;
  logic [31:0]     wdata_q;

  logic            accept;
  logic            complete;

  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   word_idx;
  logic [31:0]     cur_word;
  logic [3:0]      be;
  logic [31:0]     wlanes;
  logic [31:0]     merged;
  logic [15:0]     half_sel;
  logic [7:0]      byte_sel;
  logic [31:0]     load_data;
  logic            is_store;
  logic            trap;
  logic [31:0]     result;
  logic            mem_we;
  logic            unused_adr;

  // Handshake FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          complete = 1'b1;
          ready_d  = 1'b1;
          state_d  = StIdle;
        end
      end
    endcase
    busy_d = (state_d == StWait);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      memwrite_q   <= memwrite;
      ldsize_q     <= ldsize;
      ldunsigned_q <= ldunsigned;
      adr_q        <= dataadr;
      wdata_q      <= writedata;
    end
  end

  // Datapath: address decode, lane merge and load extraction
  assign word_idx   = adr_q[AW+1:2];
  assign cur_word   = mem[word_idx];
  assign is_store   = (memwrite_q != 2'b00);
  assign unused_adr = ^adr_q[31:AW+2];

  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_q;
    unique case (memwrite_q)
      2'b00: begin
        be     = 4'b0000;
        wlanes = wdata_q;
      end
      2'b01: begin
        be     = 4'b1111;
        wlanes = wdata_q;
      end
      2'b10: begin
        be     = adr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      2'b11: begin
        be     = 4'b0001 << adr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
    endcase
  end

  always_comb begin
    merged = cur_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = wlanes[8*k +: 8];
    end
  end

  assign half_sel = adr_q[1] ? cur_word[31:16] : cur_word[15:0];
  assign byte_sel = cur_word[{adr_q[1:0], 3'b000} +: 8];

  always_comb begin
    load_data = cur_word;
    unique case (ldsize_q)
      2'b10: load_data = ldunsigned_q ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b11: load_data = ldunsigned_q ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default: load_data = cur_word;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic word_acc;
  logic half_acc;
  logic misalign_q;

  assign word_acc = (memwrite_q == 2'b01) ||
                    ((memwrite_q == 2'b00) && ((ldsize_q == 2'b00) || (ldsize_q == 2'b01)));
  assign half_acc = (memwrite_q == 2'b10) || ((memwrite_q == 2'b00) && (ldsize_q == 2'b10));
  assign trap     = (word_acc && (adr_q[1:0] != 2'b00)) || (half_acc && adr_q[0]);

  // Flag is refreshed at every completion so it is valid alongside ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (complete) begin
      misalign_q <= trap;
    end
  end

  assign misalign = misalign_q;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  assign result     = trap ? 32'h0 : (is_store ? merged : load_data);
  assign readdata_d = complete ? result : readdata_q;
  // A reset on the completion edge abandons the access, so it must also block the write.
  assign mem_we     = complete && is_store && !trap && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= merged;
    end
  end

  assign readdata = readdata_q;
  assign ready    = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, handshake sequences, and random
// accesses checked against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req;
  logic [1:0]  memwrite;
  logic [1:0]  ldsize;
  logic        ldunsigned;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic        busy;
  logic        misalign;

  int passed = 0;
  int total  = 0;

  logic [7:0] mb [4*DEPTH];

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .memwrite   (memwrite),
    .ldsize     (ldsize),
    .ldunsigned (ldunsigned),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .readdata   (readdata),
    .ready      (ready),
    .busy       (busy),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else passed++;
  endtask

  // Reference: byte-addressed memory, accesses of 1/2/4 bytes at an address wrapped to 4*DEPTH.
  task automatic model(input logic [1:0] mw, input logic [1:0] ls, input logic lu,
                       input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ms);
    int unsigned base, size, wbase;
    logic [31:0] val;
    base = adr % (4 * DEPTH);
    if (mw == 2'd1) size = 4;
    else if (mw == 2'd2) size = 2;
    else if (mw == 2'd3) size = 1;
    else if (ls == 2'd2) size = 2;
    else if (ls == 2'd3) size = 1;
    else size = 4;
    ms = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (base % size != 0) begin
      rd = 32'h0;
      ms = 1'b1;
      return;
    end
`endif
    base = base - (base % size);
    if (mw != 2'd0) begin
      for (int i = 0; i < int'(size); i++) mb[base + i] = 8'(wd >> (8 * i));
      wbase = base - (base % 4);
      rd = {mb[wbase + 3], mb[wbase + 2], mb[wbase + 1], mb[wbase]};
    end else begin
      val = 32'h0;
      for (int i = 0; i < int'(size); i++) val = val | (32'(mb[base + i]) << (8 * i));
      if (size < 4 && !lu && val[8 * size - 1]) val = val | (32'hFFFF_FFFF << (8 * size));
      rd = val;
    end
  endtask

  // One access; optional noise drives random req/operands while busy, which must be ignored.
  task automatic access(input logic [1:0] mw, input logic [1:0] ls, input logic lu,
                        input logic [31:0] adr, input logic [31:0] wd, input bit noise,
                        output logic [31:0] rd, output logic ms);
    memwrite   = mw;
    ldsize     = ls;
    ldunsigned = lu;
    dataadr    = adr;
    writedata  = wd;
    req        = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < int'(LATENCY); i++) begin
      chk("busy_during_access", {busy, ready}, 2'b10);
      if (noise) begin
        req       = 1'($urandom_range(0, 1));
        memwrite  = 2'($urandom_range(0, 3));
        dataadr   = $urandom;
        writedata = $urandom;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    chk("ready_pulse", {busy, ready}, 2'b01);
    rd = readdata;
    ms = misalign;
    @(posedge clk); #1;
    chk("ready_clears", {busy, ready}, 2'b00);
  endtask

  typedef struct {
    logic [1:0]  mw;
    logic [1:0]  ls;
    logic        lu;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_ms;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] rd, erd;
    logic        ms, ems;

    vecs[0]  = '{2'd1, 2'd0, 1'b0, 32'd80,  32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[1]  = '{2'd2, 2'd0, 1'b0, 32'd80,  32'h0000_FFFF, 32'h1234_FFFF, 1'b0};
    vecs[2]  = '{2'd2, 2'd0, 1'b0, 32'd82,  32'h0000_ABCD, 32'hABCD_FFFF, 1'b0};
    vecs[3]  = '{2'd3, 2'd0, 1'b0, 32'd81,  32'h0000_0055, 32'hABCD_55FF, 1'b0};
    vecs[4]  = '{2'd0, 2'd3, 1'b0, 32'd83,  32'h0,         32'hFFFF_FFAB, 1'b0};
    vecs[5]  = '{2'd0, 2'd3, 1'b1, 32'd83,  32'h0,         32'h0000_00AB, 1'b0};
    vecs[6]  = '{2'd0, 2'd2, 1'b0, 32'd80,  32'h0,         32'h0000_55FF, 1'b0};
    vecs[7]  = '{2'd0, 2'd2, 1'b1, 32'd82,  32'h0,         32'h0000_ABCD, 1'b0};
    vecs[8]  = '{2'd0, 2'd1, 1'b0, 32'd80 + 4 * DEPTH, 32'h0, 32'hABCD_55FF, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[9]  = '{2'd2, 2'd0, 1'b0, 32'd81,  32'h0000_1111, 32'h0,         1'b1};
    vecs[10] = '{2'd0, 2'd1, 1'b0, 32'd80,  32'h0,         32'hABCD_55FF, 1'b0};
`else
    vecs[9]  = '{2'd2, 2'd0, 1'b0, 32'd81,  32'h0000_1111, 32'hABCD_1111, 1'b0};
    vecs[10] = '{2'd0, 2'd1, 1'b0, 32'd80,  32'h0,         32'hABCD_1111, 1'b0};
`endif

    // Reset held two cycles with a request pending
    reset = 1'b1;
    req = 1'b1; memwrite = 2'd1; ldsize = 2'd0; ldunsigned = 1'b0;
    dataadr = 32'd80; writedata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {ready, busy, misalign}, 3'b000);
    chk("reset_readdata", readdata, 32'h0);
    req = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("no_accept_in_reset", {ready, busy}, 2'b00);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      access(vecs[i].mw, vecs[i].ls, vecs[i].lu, vecs[i].adr, vecs[i].wd, i == 0, rd, ms);
      chk($sformatf("vec%0d_readdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_misalign", i), ms, vecs[i].exp_ms);
    end

    // Fill all of storage so the model and DUT agree everywhere
    for (int w = 0; w < int'(DEPTH); w++) begin
      model(2'd1, 2'd0, 1'b0, 32'(4 * w), $urandom, erd, ems);
      access(2'd1, 2'd0, 1'b0, 32'(4 * w), erd, 1'b0, rd, ms);
      chk("fill_readdata", rd, erd);
    end

    // Back-to-back: req held through the ready cycle, load sees the just-committed store
    model(2'd1, 2'd0, 1'b0, 32'd88, 32'h0BAD_CAFE, erd, ems);
    memwrite = 2'd1; ldsize = 2'd0; ldunsigned = 1'b0; dataadr = 32'd88;
    writedata = 32'h0BAD_CAFE; req = 1'b1;
    @(posedge clk); #1;
    memwrite = 2'd0; ldsize = 2'd1;
    for (int i = 0; i < int'(LATENCY); i++) begin
      chk("b2b_busy1", {busy, ready}, 2'b10);
      @(posedge clk); #1;
    end
    chk("b2b_ready1", {busy, ready}, 2'b01);
    chk("b2b_store_rd", readdata, erd);
    @(posedge clk); #1;
    req = 1'b0;
    chk("b2b_accept2", {busy, ready}, 2'b10);
    repeat (LATENCY) @(posedge clk);
    #1;
    model(2'd0, 2'd1, 1'b0, 32'd88, 32'h0, erd, ems);
    chk("b2b_ready2", {busy, ready}, 2'b01);
    chk("b2b_load_rd", readdata, erd);
    @(posedge clk); #1;

    // Random accesses against the reference
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  mw, ls;
      logic        lu;
      logic [31:0] adr, wd;
      mw  = 2'($urandom_range(0, 3));
      ls  = 2'($urandom_range(0, 3));
      lu  = 1'($urandom_range(0, 1));
      adr = $urandom;
      wd  = $urandom;
      model(mw, ls, lu, adr, wd, erd, ems);
      access(mw, ls, lu, adr, wd, bit'($urandom_range(0, 1)), rd, ms);
      chk($sformatf("rand%0d_readdata", n), rd, erd);
      chk($sformatf("rand%0d_misalign", n), ms, ems);
    end

    // Reset on the completion edge abandons the store
    memwrite = 2'd1; ldsize = 2'd0; dataadr = 32'd84; writedata = 32'hDEAD_BEEF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (LATENCY - 1) @(posedge clk);
    #1;
    chk("midop_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midop_no_ready", {ready, busy}, 2'b00);
    chk("midop_readdata", readdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midop_idle", {ready, busy}, 2'b00);
    model(2'd0, 2'd1, 1'b0, 32'd84, 32'h0, erd, ems);
    access(2'd0, 2'd1, 1'b0, 32'd84, 32'h0, 1'b0, rd, ms);
    chk("midop_prior_contents", rd, erd);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: the memory-side end of the store/load interface driven by the MEM stage. It accepts one access per request (sw/sh/sb stores, lw/lh/lhu/lb/lbu loads), models configurable access latency with a busy/ready handshake that the hazard unit uses to stall, merges partial stores into word storage by byte lane, and returns sign- or zero-extended load data.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words; power of two, ≥ 4
- LATENCY, 2, cycles from acceptance to completion; ≥ 1

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  access request; sampled only when idle
- memwrite  in  2  00 load, 01 sw, 10 sh, 11 sb
- ldsize  in  2  load width when memwrite=00: 01 word, 10 half, 11 byte; 00 treated as word
- ldunsigned  in  1  1 = zero-extend half/byte loads
- dataadr  in  32  byte address
- writedata  in  32  store data, right-aligned (sh uses [15:0], sb uses [7:0])
- readdata  out  32  load result, or merged word after a store
- ready  out  1  one-cycle completion pulse
- busy  out  1  access in flight; core stalls while high
- misalign  out  1  misaligned access flag, valid with ready

## Operation
- States: IDLE, WAIT. Counter cnt, width ⌈log2 LATENCY⌉ (min 1).
- IDLE & req at edge: latch memwrite, ldsize, ldunsigned, dataadr, writedata; cnt ← LATENCY-1; → WAIT. req while WAIT ignored; latched operands unaffected by input changes.
- WAIT, cnt≠0: cnt ← cnt-1.
- WAIT, cnt=0: perform access, ready ← 1, readdata updated, → IDLE.
- Word index = dataadr[log2(DEPTH)+1:2]; upper bits ignored (address wraps modulo DEPTH words).
- Little-endian lanes: byte k of word = bits [8k+7:8k], k = dataadr[1:0].
- sw writes all 4 lanes; sh writes lanes {2·a1, 2·a1+1} with writedata[15:0]; sb writes lane k with writedata[7:0]; other lanes unchanged.
- Store: readdata ← merged word after write.
- Load: lw returns word; lh selects half a1, lb selects lane k; sign-extend from bit 15/7 unless ldunsigned.
- Storage not cleared by reset; initial contents undefined (bench must write before read).

## Timing
- Reset values: state IDLE, cnt 0, ready 0, busy 0, readdata 0, misalign 0.
- Acceptance at edge E0 → busy = 1 for exactly LATENCY cycles (after E0 through E_LATENCY) → ready = 1 for one cycle after E_LATENCY, busy = 0 in that cycle.
- Back-to-back: req held high during the ready cycle is accepted at the next edge; sustained throughput one access per LATENCY+1 cycles.
- Store write commits at E_LATENCY; a load accepted in the ready cycle sees the new data.
- busy and ready are registered; never high simultaneously.
- Reset asserted at any edge in WAIT, including the completion edge: access abandoned, no write, no ready pulse.
- ready, readdata, misalign hold reset/previous values except: ready auto-clears after one cycle; readdata holds last result until next completion.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: sw/lw with dataadr[1:0]≠0 or sh/lh with dataadr[0]=1 are misaligned; at completion no storage write, readdata ← 0, misalign ← 1 for the ready cycle; timing unchanged.
- Undefined: misalign tied 0; misaligned addresses silently aligned down (sw/lw ignore [1:0], sh/lh ignore [0]) and access performed normally.

## Test plan
- Reset: hold reset 2 cycles → ready, busy, readdata, misalign all 0; req during reset not accepted.
- Handshake, LATENCY=2: sw 0x12345678 to 80 → busy high 2 cycles, ready pulse 1 cycle after 2nd edge, readdata 0x12345678; req pulses while busy ignored.
- Partial stores: after above, sh 0x0000FFFF to 80 → word 20 = 0x1234FFFF; sh 0xABCD to 82 → 0xABCDFFFF; sb 0x55 to 81 → 0xABCD55FF.
- Loads on 0xABCD55FF at 80: lb 83 → 0xFFFFFFAB; lbu 83 → 0x000000AB; lh 80 → 0x000055FF; lhu 82 → 0x0000ABCD; lw 80+4·DEPTH → 0xABCD55FF (wrap).
- Misalign: sh 0x1111 to 81 → with macro: misalign=1, readdata 0, word unchanged; without: lanes 0–1 of word 20 = 0x1111, misalign=0.
- Reset mid-op: accept sw 0xDEADBEEF to 84, assert reset at completion edge → no ready; subsequent lw 84 returns prior contents.
